iob_caravel_counter: RTL and testbench

IOB_CARAVEL_COUNTER -- requirements
Module: iob_caravel_counter

---
 rtl/iob_caravel_counter_pkg.sv | 15 +
 rtl/iob_caravel_counter_regs.sv | 112 +++++++++++
 rtl/iob_caravel_counter.sv | 74 +++++++
 tb/tb_iob_caravel_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_caravel_counter_pkg.sv
// Shared register map and CTRL bit positions for the caravel counter block.
package iob_caravel_counter_pkg;

    localparam int ADDR_CTRL   = 'h00;
    localparam int ADDR_LOAD   = 'h04;
    localparam int ADDR_COUNT  = 'h08;
    localparam int ADDR_CMP    = 'h0C;
    localparam int ADDR_STATUS = 'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DOWN   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

endpackage

// File: rtl/iob_caravel_counter_regs.sv
// IOb register file: CTRL/LOAD/CMP/STATUS storage and COUNT write requests; reads return
// one cycle after acceptance; ready drops only while the logic-analyser override is active.
module iob_caravel_counter_regs
    import iob_caravel_counter_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BITS   = 16
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    input  logic                la_ovr_i,
    input  logic [BITS-1:0]     count,
    input  logic [BITS-1:0]     count_nxt,
    output logic                count_wr,
    output logic [BITS-1:0]     count_wr_dat,
    output logic                en,
    output logic                down,
    output logic                irq_en,
    output logic                match
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [BITS-1:0]   load_q;
    logic [BITS-1:0]   cmp_q;
    logic              match_q;
    logic              accept, wr, rd;
    logic              sel_ctrl, sel_load, sel_count, sel_cmp, sel_status;
    logic [BITS-1:0]   load_new, count_new, cmp_new;
    logic [CTRL_W-1:0] ctrl_new;
    logic              match_set, match_clr;
    logic [DATA_W-1:0] rd_dat;
    logic              unused_bits;

    function automatic logic [BITS-1:0] merge(input logic [BITS-1:0] old);
        logic [BITS-1:0] r;
        for (int i = 0; i < BITS; i++)
            r[i] = iob_wstrb_i[i/8] ? iob_wdata_i[i] : old[i];
        return r;
    endfunction

    assign unused_bits = ^{iob_wdata_i, iob_wstrb_i};

    assign iob_ready_o = ~la_ovr_i;
    assign accept      = iob_valid_i & iob_ready_o & cke_i;
    assign wr          = accept & (|iob_wstrb_i);
    assign rd          = accept & ~(|iob_wstrb_i);

    assign sel_ctrl   = (iob_addr_i == ADDR_W'(ADDR_CTRL));
    assign sel_load   = (iob_addr_i == ADDR_W'(ADDR_LOAD));
    assign sel_count  = (iob_addr_i == ADDR_W'(ADDR_COUNT));
    assign sel_cmp    = (iob_addr_i == ADDR_W'(ADDR_CMP));
    assign sel_status = (iob_addr_i == ADDR_W'(ADDR_STATUS));

    assign ctrl_new  = iob_wstrb_i[0] ? iob_wdata_i[CTRL_W-1:0] : ctrl_q;
    assign load_new  = merge(load_q);
    assign count_new = merge(count);
    assign cmp_new   = merge(cmp_q);

    // A LOAD write also reloads COUNT with the freshly merged LOAD value.
    assign count_wr     = wr & (sel_load | sel_count);
    assign count_wr_dat = sel_load ? load_new : count_new;

    // Compare against the value COUNT takes at this edge, so MATCH rises with COUNT.
    assign match_set = (count_nxt == cmp_q);
    assign match_clr = wr & sel_status & iob_wstrb_i[0] & iob_wdata_i[0];

    always_comb begin
        rd_dat = '0;
        if (sel_ctrl)   rd_dat = DATA_W'(ctrl_q);
        if (sel_load)   rd_dat = DATA_W'(load_q);
        if (sel_count)  rd_dat = DATA_W'(count);
        if (sel_cmp)    rd_dat = DATA_W'(cmp_q);
        if (sel_status) rd_dat = DATA_W'(match_q);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ctrl_q       <= '0;
            load_q       <= '0;
            cmp_q        <= '1;
            match_q      <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else begin
            // Response path is not held by cke so rvalid never stretches past one cycle.
            iob_rvalid_o <= rd;
            iob_rdata_o  <= rd ? rd_dat : '0;
            if (cke_i) begin
                if (wr && sel_ctrl) ctrl_q <= ctrl_new;
                if (wr && sel_load) load_q <= load_new;
                if (wr && sel_cmp)  cmp_q  <= cmp_new;
                if (match_set)      match_q <= 1'b1;
                else if (match_clr) match_q <= 1'b0;
            end
        end
    end

    assign en     = ctrl_q[CTRL_EN];
    assign down   = ctrl_q[CTRL_DOWN];
    assign irq_en = ctrl_q[CTRL_IRQ_EN];
    assign match  = match_q;

endmodule

// File: rtl/iob_caravel_counter.sv
// Up/down counter with IOb register access and logic-analyser override; COUNT updates
// at the edge after a request; ready is ~la_ovr_i, no other backpressure.
module iob_caravel_counter
    import iob_caravel_counter_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BITS   = 16
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    input  logic                la_ovr_i,
    input  logic [BITS-1:0]     la_val_i,
    output logic [BITS-1:0]     count_o,
    output logic [BITS-1:0]     io_oeb_o,
    output logic                irq_o
);

    logic [BITS-1:0] count_q, count_nxt, count_wr_dat;
    logic            count_wr, en, down, irq_en, match;

    iob_caravel_counter_regs #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BITS  (BITS)
    ) u_regs (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .iob_valid_i (iob_valid_i),
        .iob_addr_i  (iob_addr_i),
        .iob_wdata_i (iob_wdata_i),
        .iob_wstrb_i (iob_wstrb_i),
        .iob_ready_o (iob_ready_o),
        .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o (iob_rdata_o),
        .la_ovr_i    (la_ovr_i),
        .count       (count_q),
        .count_nxt   (count_nxt),
        .count_wr    (count_wr),
        .count_wr_dat(count_wr_dat),
        .en          (en),
        .down        (down),
        .irq_en      (irq_en),
        .match       (match)
    );

    always_comb begin
        count_nxt = count_q;
        if (cke_i) begin
            if (la_ovr_i)      count_nxt = la_val_i;
            else if (count_wr) count_nxt = count_wr_dat;
            else if (en)       count_nxt = down ? count_q - BITS'(1) : count_q + BITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) count_q <= '0;
        else           count_q <= count_nxt;
    end

    assign count_o  = count_q;
    assign io_oeb_o = {BITS{~en}};
    assign irq_o    = match & irq_en;

endmodule

// File: tb/tb_iob_caravel_counter.sv
// Randomized and directed bench for iob_caravel_counter against a register-level model.
module tb_iob_caravel_counter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int BITS   = 16;
    localparam logic [31:0] MASK = 32'h0000_FFFF;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              cke;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              ready, rvalid;
    logic [DATA_W-1:0] rdata;
    logic              la_ovr;
    logic [BITS-1:0]   la_val;
    logic [BITS-1:0]   count, oeb;
    logic              irq;

    int total  = 0;
    int passed = 0;

    // model state: register contents as the spec defines them
    logic [31:0] m_ctrl, m_load, m_count, m_cmp, m_rd;
    logic        m_match, m_rv;

    always #5 clk = ~clk;

    iob_caravel_counter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BITS(BITS)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata),
        .la_ovr_i(la_ovr), .la_val_i(la_val),
        .count_o(count), .io_oeb_o(oeb), .irq_o(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_load = 0; m_count = 0; m_cmp = MASK; m_match = 0; m_rv = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_val(input int a);
        case (a)
            'h00: return m_ctrl;
            'h04: return m_load;
            'h08: return m_count;
            'h0C: return m_cmp;
            'h10: return {31'b0, m_match};
            default: return 0;
        endcase
    endfunction

    task automatic compare_outputs();
        chk("count_o", {16'b0, count}, m_count);
        chk("io_oeb_o", {16'b0, oeb}, m_ctrl[0] ? 32'h0 : MASK);
        chk("irq_o", {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
        chk("rvalid", {31'b0, rvalid}, {31'b0, m_rv});
        chk("rdata", rdata, m_rd);
    endtask

    // one clock cycle: drive at negedge, predict, check after the rising edge
    task automatic cyc(input bit v, input int a, input logic [31:0] wd, input logic [3:0] st,
                       input bit ovr, input logic [15:0] lv, input bit ck);
        bit acc, wr, rd;
        logic [31:0] n_ctrl, n_load, n_count, n_cmp;
        logic n_match;
        @(negedge clk);
        valid = v; addr = a[4:0]; wdata = wd; wstrb = st; la_ovr = ovr; la_val = lv; cke = ck;
        #1 chk("ready", {31'b0, ready}, {31'b0, ~ovr});
        acc = v && !ovr && ck;
        wr  = acc && (st != 0);
        rd  = acc && (st == 0);
        n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_cmp = m_cmp; n_match = m_match;
        if (ck) begin
            if (wr && a == 'h00) n_ctrl = mrg(m_ctrl, wd, st) & 32'h7;
            if (wr && a == 'h04) n_load = mrg(m_load, wd, st) & MASK;
            if (wr && a == 'h0C) n_cmp  = mrg(m_cmp, wd, st) & MASK;
            if (ovr)                   n_count = {16'b0, lv};
            else if (wr && a == 'h04)  n_count = n_load;
            else if (wr && a == 'h08)  n_count = mrg(m_count, wd, st) & MASK;
            else if (m_ctrl[0])        n_count = (m_ctrl[1] ? m_count - 1 : m_count + 1) & MASK;
            if (n_count == m_cmp) n_match = 1'b1;
            else if (wr && a == 'h10 && st[0] && wd[0]) n_match = 1'b0;
        end
        m_rv = rd;
        m_rd = rd ? reg_val(a) : 32'h0;
        @(posedge clk);
        #1;
        m_ctrl = n_ctrl; m_load = n_load; m_count = n_count; m_cmp = n_cmp; m_match = n_match;
        compare_outputs();
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d, input logic [3:0] st);
        cyc(1, a, d, st, 0, 16'h0, 1);
    endtask
    task automatic rd_reg(input int a);
        cyc(1, a, 32'h0, 4'h0, 0, 16'h0, 1);
    endtask
    task automatic idle();
        cyc(0, 0, 32'h0, 4'h0, 0, 16'h0, 1);
    endtask

    initial begin
        arst_n = 0; cke = 1; valid = 0; addr = 0; wdata = 0; wstrb = 0; la_ovr = 0; la_val = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst count_o", {16'b0, count}, 32'h0);
        chk("rst io_oeb_o", {16'b0, oeb}, 32'hFFFF);
        chk("rst irq_o", {31'b0, irq}, 32'h0);
        chk("rst rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        la_ovr = 1; #1 chk("rst ready follows ovr", {31'b0, ready}, 32'h0);
        la_ovr = 0; #1 chk("rst ready", {31'b0, ready}, 32'h1);
        @(negedge clk) arst_n = 1;

        // count up through the wrap, then reverse
        wr_reg('h04, 32'hFFFE, 4'hF); chk("load->count", {16'b0, count}, 32'hFFFE);
        wr_reg('h00, 32'h1, 4'hF);    chk("cnt0", {16'b0, count}, 32'hFFFE);
        idle();                        chk("cnt1", {16'b0, count}, 32'hFFFF);
        idle();                        chk("cnt2", {16'b0, count}, 32'h0000);
        wr_reg('h00, 32'h3, 4'hF);    chk("cnt3", {16'b0, count}, 32'h0001);
        idle();                        chk("dn1", {16'b0, count}, 32'h0000);
        idle();                        chk("dn2", {16'b0, count}, 32'hFFFF);

        // match and interrupt
        wr_reg('h00, 32'h0, 4'hF);
        wr_reg('h10, 32'h1, 4'hF);
        wr_reg('h0C, 32'h10, 4'hF);
        wr_reg('h00, 32'h5, 4'hF);
        wr_reg('h04, 32'h0C, 4'hF);   chk("irq low before", {31'b0, irq}, 32'h0);
        repeat (3) idle();
        idle();                        chk("count at cmp", {16'b0, count}, 32'h10);
        chk("irq at match", {31'b0, irq}, 32'h1);
        rd_reg('h10);                  chk("status read", rdata, 32'h1);
        wr_reg('h10, 32'h1, 4'h1);    chk("irq cleared", {31'b0, irq}, 32'h0);

        // read latency and unmapped read
        rd_reg('h08);                  chk("rvalid N+1", {31'b0, rvalid}, 32'h1);
        idle();                        chk("rvalid one cycle", {31'b0, rvalid}, 32'h0);
        rd_reg('h14);                  chk("unmapped rvalid", {31'b0, rvalid}, 32'h1);
        chk("unmapped rdata", rdata, 32'h0);

        // W1C colliding with a new match
        wr_reg('h0C, (m_count + 3) & MASK, 4'hF);
        idle();                        chk("no match yet", {31'b0, irq}, 32'h0);
        wr_reg('h10, 32'h1, 4'h1);    chk("set beats clear", {31'b0, irq}, 32'h1);

        // byte-lane write into LOAD
        wr_reg('h04, 32'h0012, 4'hF);
        wr_reg('h04, 32'hAB00, 4'h2); chk("byte lane count", {16'b0, count}, 32'hAB12);
        rd_reg('h04);                  chk("byte lane load", rdata, 32'hAB12);

        // override blocks the bus and forces COUNT
        cyc(1, 'h04, 32'h5555, 4'hF, 1, 16'h1234, 1);
        chk("ovr count", {16'b0, count}, 32'h1234);
        rd_reg('h04);                  chk("ovr write dropped", rdata, 32'hAB12);

        // reset while a read response is pending
        rd_reg('h08);
        arst_n = 0;
        #1 chk("rst drops rvalid", {31'b0, rvalid}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1;
        idle();                        chk("no rvalid after rst", {31'b0, rvalid}, 32'h0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            int a;
            logic [31:0] d;
            logic [3:0] s;
            a = $urandom_range(0, 7);
            a = (a < 6) ? a * 4 : $urandom_range(0, 31);
            d = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            s = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            cyc($urandom_range(0, 1), a, d, s, $urandom_range(0, 15) == 0,
                16'($urandom), $urandom_range(0, 15) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
